// File: rtl/regfile_read_sb.sv
// Register-file read side: two registered read ports, one write port and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_read_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   r_ra_data;
  logic [DATA_W-1:0]   r_rb_data;

  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_set_hit;
  logic [DATA_W-1:0]   w_ra_next;
  logic [DATA_W-1:0]   w_rb_next;
  logic                w_wr_valid;
  logic                w_iss_fire;
  logic                w_byp_a;
  logic                w_byp_b;
  logic                w_busy_a;
  logic                w_busy_b;
  logic                w_stall;

  assign w_wr_valid = we & (wa_addr != '0);
  // An issue that arrives while decode is stalled belongs to a held instruction and must not mark anything.
  assign w_iss_fire = iss_en & ~w_stall & (iss_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_strobe
      assign w_wr_hit[gi]  = w_wr_valid & (wa_addr == ADDR_W'(gi));
      assign w_set_hit[gi] = w_iss_fire & (iss_addr == ADDR_W'(gi));
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  assign w_byp_a  = w_wr_valid & (wa_addr == ra_addr);
  assign w_byp_b  = w_wr_valid & (wa_addr == rb_addr);
  assign w_busy_a = r_busy[ra_addr] & ~(we & (wa_addr == ra_addr));
  assign w_busy_b = r_busy[rb_addr] & ~(we & (wa_addr == rb_addr));
`else
  assign w_byp_a  = 1'b0;
  assign w_byp_b  = 1'b0;
  assign w_busy_a = r_busy[ra_addr];
  assign w_busy_b = r_busy[rb_addr];
`endif

  assign w_stall = rd_en & (w_busy_a | w_busy_b);

  always_comb begin
    w_ra_next = r_regs[ra_addr];
    w_rb_next = r_regs[rb_addr];
    if (w_byp_a) w_ra_next = wa_data;
    if (w_byp_b) w_rb_next = wa_data;
    if (ra_addr == '0) w_ra_next = '0;
    if (rb_addr == '0) w_rb_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit[i]) r_regs[i] <= wa_data;
      end
    end
  end

  // Set has priority over clear so a newer in-flight producer keeps its register marked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_set_hit[i])     r_busy[i] <= 1'b1;
        else if (w_wr_hit[i]) r_busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else if (rd_en) begin
      r_ra_data <= w_ra_next;
      r_rb_data <= w_rb_next;
    end
  end

  assign ra_data = r_ra_data;
  assign rb_data = r_rb_data;
  assign busy_a  = w_busy_a;
  assign busy_b  = w_busy_b;
  assign stall   = w_stall;

endmodule
